// File: rtl/instr_encoder.sv
// instr_encoder: builds RV32I instruction words from decoded fields, checks
// immediate range/alignment, and streams accepted words with their byte
// address through a single-entry valid/ready output register.
module instr_encoder #(
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [31:0]       out_addr,
    output logic [ADDR_W:0]   word_count,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [7:0]        err_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] FMT_R      = 3'd0;
    localparam logic [2:0] FMT_I      = 3'd1;
    localparam logic [2:0] FMT_LOAD   = 3'd2;
    localparam logic [2:0] FMT_STORE  = 3'd3;
    localparam logic [2:0] FMT_BRANCH = 3'd4;
    localparam logic [2:0] FMT_JAL    = 3'd5;
    localparam logic [2:0] FMT_JALR   = 3'd6;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_RANGE   = 2'd1;
    localparam logic [1:0] ERR_ALIGN   = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL = 2'd3;

    localparam logic [ADDR_W:0]   CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

    // Inclusive signed window test for the immediate.
    function automatic logic in_window(input logic signed [31:0] v,
                                       input logic signed [31:0] lo,
                                       input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Saturating increment of the emitted-word counter.
    function automatic logic [ADDR_W:0] sat_inc_cnt(input logic [ADDR_W:0] v);
        return (v == CNT_MAX) ? v : v + (ADDR_W+1)'(1);
    endfunction

    // Saturating increment of the rejected-request counter.
    function automatic logic [7:0] sat_inc_err(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic signed [31:0] imm_p0;
    logic [31:0]        enc_p0;
    logic [1:0]         code_p0;
    logic [31:0]        data_p1;
    logic               vld_p1;
    logic [ADDR_W-1:0]  word_idx;
    logic               accept;
    logic               fire;

    assign imm_p0 = imm;

    // Scatter the fields into the word layout selected by fmt.
    always_comb begin
        enc_p0 = 32'h0;
        case (fmt)
            FMT_R:      enc_p0 = {funct7, rs2, rs1, funct3, rd, OP_R};
            FMT_I:      enc_p0 = {imm[11:0], rs1, funct3, rd, OP_I};
            FMT_LOAD:   enc_p0 = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            FMT_STORE:  enc_p0 = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            FMT_BRANCH: enc_p0 = {imm[12], imm[10:5], rs2, rs1, funct3,
                                  imm[4:1], imm[11], OP_BRANCH};
            FMT_JAL:    enc_p0 = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            FMT_JALR:   enc_p0 = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            default:    enc_p0 = 32'h0;
        endcase
    end

    // Classify the request; a range failure outranks misalignment.
    always_comb begin
        code_p0 = ERR_NONE;
        case (fmt)
            FMT_R: code_p0 = ERR_NONE;
            FMT_I, FMT_LOAD, FMT_STORE, FMT_JALR: begin
                if (!in_window(imm_p0, -32'sd2048, 32'sd2047))
                    code_p0 = ERR_RANGE;
            end
            FMT_BRANCH: begin
                if (!in_window(imm_p0, -32'sd4096, 32'sd4094))
                    code_p0 = ERR_RANGE;
                else if (imm[0])
                    code_p0 = ERR_ALIGN;
            end
            FMT_JAL: begin
                if (!in_window(imm_p0, -32'sd1048576, 32'sd1048574))
                    code_p0 = ERR_RANGE;
                else if (imm[0])
                    code_p0 = ERR_ALIGN;
            end
            default: code_p0 = ERR_ILLEGAL;
        endcase
    end

    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;
    assign fire     = vld_p1 && out_ready;

    // ---- stage p1: output register, address/count and error bookkeeping ----
    // Output register, word index, counters and error state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            data_p1    <= 32'h0;
            word_idx   <= '0;
            word_count <= '0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            err_count  <= 8'h0;
        end else if (clear) begin
            vld_p1     <= 1'b0;
            data_p1    <= 32'h0;
            word_idx   <= '0;
            word_count <= '0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            err_count  <= 8'h0;
        end else begin
            if (fire) begin
                word_idx   <= word_idx + IDX_ONE;
                word_count <= sat_inc_cnt(word_count);
            end
            if (accept && (code_p0 == ERR_NONE)) begin
                vld_p1  <= 1'b1;
                data_p1 <= enc_p0;
            end else if (fire) begin
                vld_p1 <= 1'b0;
            end
            if (accept && (code_p0 != ERR_NONE)) begin
                err       <= 1'b1;
                err_code  <= code_p0;
                err_count <= sat_inc_err(err_count);
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_addr  = BASE_ADDR + {{(30-ADDR_W){1'b0}}, word_idx, 2'b00};

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed-vector bench for instr_encoder. A second instance
// with ADDR_W=2 shares the request inputs and is used for the address-wrap case.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  fmt = 3'd0;
    logic [4:0]  rd = 5'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [6:0]  funct7 = 7'd0;
    logic [31:0] imm = 32'd0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, err;
    logic [31:0] out_data, out_addr;
    logic [6:0]  word_count;
    logic [1:0]  err_code;
    logic [7:0]  err_count;

    logic        in_ready2, out_valid2, err2;
    logic [31:0] out_data2, out_addr2;
    logic [2:0]  word_count2;
    logic [1:0]  err_code2;
    logic [7:0]  err_count2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  f;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    instr_encoder #(.ADDR_W(6), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr),
        .word_count(word_count), .err(err),
        .err_code(err_code), .err_count(err_count)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(32'h0)) dut2 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready2),
        .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_addr(out_addr2),
        .word_count(word_count2), .err(err2),
        .err_code(err_code2), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] f, input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] im);
        fmt = f; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 00000000", out_data); end
        checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL reset_out_addr: got %h want 00000000", out_addr); end
        checks++; if (word_count !== 7'd0) begin errors++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
        checks++; if ({err, err_code, err_count} !== 11'h0) begin errors++; $display("FAIL reset_err: got %b/%0d/%0d want 0/0/0", err, err_code, err_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_itype();
        out_ready = 1'b1;
        set_req(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 32'h00500093) begin errors++; $display("FAIL addi_data: got %h want 00500093", out_data); end
        checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL addi_addr: got %h want 00000000", out_addr); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain: got %b want 0", out_valid); end
        checks++; if (word_count !== 7'd1) begin errors++; $display("FAIL addi_count: got %0d want 1", word_count); end
        checks++; if (out_addr !== 32'h4) begin errors++; $display("FAIL addi_next_addr: got %h want 00000004", out_addr); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        set_req(3'd3, 5'd0, 5'd0, 5'd2, 3'd2, 7'd0, 32'd8);
        in_valid = 1'b1;
        tick();
        checks++; if (out_data !== 32'h00202423 || out_valid !== 1'b1) begin errors++; $display("FAIL sw_data: got %h/%b want 00202423/1", out_data, out_valid); end
        checks++; if (out_addr !== 32'h4) begin errors++; $display("FAIL sw_addr: got %h want 00000004", out_addr); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
        set_req(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
        tick();
        in_valid = 1'b0;
        checks++; if (out_data !== 32'hFE000EE3 || out_valid !== 1'b1) begin errors++; $display("FAIL beq_data: got %h/%b want FE000EE3/1", out_data, out_valid); end
        checks++; if (out_addr !== 32'h8) begin errors++; $display("FAIL beq_addr: got %h want 00000008", out_addr); end
        tick();
        checks++; if (word_count !== 7'd3 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_count: got %0d/%b want 3/0", word_count, out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        set_req(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 32'h008000EF) begin errors++; $display("FAIL jal_hold[%0d]: got %h/%b want 008000EF/1", i, out_data, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
            checks++; if (out_addr !== 32'hC) begin errors++; $display("FAIL stall_addr[%0d]: got %h want 0000000C", i, out_addr); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || word_count !== 7'd4) begin errors++; $display("FAIL release_count: got %b/%0d want 0/4", out_valid, word_count); end
        checks++; if (out_addr !== 32'h10) begin errors++; $display("FAIL release_addr: got %h want 00000010", out_addr); end
    endtask

    task automatic test_encodings();
        vec_t v[8];
        v[0] = '{3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,          32'h002081B3}; // add x3,x1,x2
        v[1] = '{3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,          32'h402081B3}; // sub x3,x1,x2
        v[2] = '{3'd6, 5'd0, 5'd1, 5'd0, 3'd7, 7'h00, 32'd0,          32'h00008067}; // jalr x0,0(x1)
        v[3] = '{3'd2, 5'd5, 5'd2, 5'd0, 3'd2, 7'h00, 32'hFFFF_FFFF,  32'hFFF12283}; // lw x5,-1(x2)
        v[4] = '{3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800,  32'h80000093}; // addi -2048
        v[5] = '{3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2047,       32'h7FF00093}; // addi 2047
        v[6] = '{3'd4, 5'd0, 5'd1, 5'd2, 3'd1, 7'h00, 32'd4094,       32'h7E209FE3}; // bne +4094
        v[7] = '{3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800,  32'h801FF06F}; // jal x0,-2048
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_req(v[i].f, v[i].rd, v[i].rs1, v[i].rs2, v[i].f3, v[i].f7, v[i].imm);
            tick();
            checks++; if (out_data !== v[i].exp || out_valid !== 1'b1) begin errors++; $display("FAIL enc[%0d]_data: got %h/%b want %h/1", i, out_data, out_valid, v[i].exp); end
            checks++; if (out_addr !== 32'(16 + 4*i)) begin errors++; $display("FAIL enc[%0d]_addr: got %h want %h", i, out_addr, 32'(16 + 4*i)); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (word_count !== 7'd12) begin errors++; $display("FAIL enc_count: got %0d want 12", word_count); end
    endtask

    task automatic test_errors();
        do_clear();
        checks++; if (word_count !== 7'd0 || out_addr !== 32'h0) begin errors++; $display("FAIL clear_state: got %0d/%h want 0/00000000", word_count, out_addr); end
        out_ready = 1'b1;
        set_req(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (err !== 1'b1 || err_code !== 2'd1 || err_count !== 8'd1) begin errors++; $display("FAIL err_range: got %b/%0d/%0d want 1/1/1", err, err_code, err_count); end
        checks++; if (out_valid !== 1'b0 || out_addr !== 32'h0) begin errors++; $display("FAIL err_range_out: got %b/%h want 0/00000000", out_valid, out_addr); end
        set_req(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (err_code !== 2'd2 || err_count !== 8'd2) begin errors++; $display("FAIL err_align: got %0d/%0d want 2/2", err_code, err_count); end
        checks++; if (out_valid !== 1'b0 || out_addr !== 32'h0) begin errors++; $display("FAIL err_align_out: got %b/%h want 0/00000000", out_valid, out_addr); end
        set_req(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (err_code !== 2'd3 || err_count !== 8'd3) begin errors++; $display("FAIL err_illegal: got %0d/%0d want 3/3", err_code, err_count); end
        checks++; if (out_valid !== 1'b0 || out_addr !== 32'h0 || word_count !== 7'd0) begin errors++; $display("FAIL err_illegal_out: got %b/%h/%0d want 0/00000000/0", out_valid, out_addr, word_count); end
        set_req(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4095);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (err_code !== 2'd1 || err_count !== 8'd4) begin errors++; $display("FAIL err_both: got %0d/%0d want 1/4", err_code, err_count); end
        set_req(3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (err_code !== 2'd1 || err_count !== 8'd5) begin errors++; $display("FAIL err_jal_range: got %0d/%0d want 1/5", err_code, err_count); end
        set_req(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h00500093 || err !== 1'b1 || err_code !== 2'd1) begin errors++; $display("FAIL err_sticky: got %b/%h/%b/%0d want 1/00500093/1/1", out_valid, out_data, err, err_code); end
        tick();
    endtask

    task automatic test_err_saturation();
        do_clear();
        set_req(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 256; i++) tick();
        in_valid = 1'b0;
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL err_count_sat: got %0d want 255", err_count); end
    endtask

    task automatic test_wrap();
        do_clear();
        out_ready = 1'b1;
        set_req(3'd1, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (out_addr2 !== 32'((4*i) % 16) || out_valid2 !== 1'b1) begin errors++; $display("FAIL wrap_addr[%0d]: got %h/%b want %h/1", i, out_addr2, out_valid2, 32'((4*i) % 16)); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (word_count2 !== 3'd4) begin errors++; $display("FAIL wrap_count_sat: got %0d want 4", word_count2); end
        checks++; if (out_addr2 !== 32'h4) begin errors++; $display("FAIL wrap_final_addr: got %h want 00000004", out_addr2); end
        checks++; if (word_count !== 7'd5) begin errors++; $display("FAIL wide_count: got %0d want 5", word_count); end
    endtask

    task automatic test_async_reset();
        do_clear();
        out_ready = 1'b1;
        set_req(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        set_req(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        in_valid = 1'b1;
        tick();
        out_ready = 1'b0;
        set_req(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || word_count !== 7'd1 || err_count !== 8'd1) begin errors++; $display("FAIL pre_reset: got %b/%0d/%0d want 1/1/1", out_valid, word_count, err_count); end
        #3 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL async_reset_out: got %b/%h want 0/00000000", out_valid, out_data); end
        checks++; if (word_count !== 7'd0 || err_count !== 8'd0 || err !== 1'b0 || err_code !== 2'd0) begin errors++; $display("FAIL async_reset_cnt: got %0d/%0d/%b/%0d want 0/0/0/0", word_count, err_count, err, err_code); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_clear_with_accept();
        out_ready = 1'b1;
        set_req(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        in_valid = 1'b1;
        tick();
        set_req(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (word_count !== 7'd1 || err_count !== 8'd1) begin errors++; $display("FAIL pre_clear: got %0d/%0d want 1/1", word_count, err_count); end
        set_req(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        in_valid = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL clear_drop: got %b/%h want 0/00000000", out_valid, out_data); end
        checks++; if (word_count !== 7'd0 || err_count !== 8'd0 || out_addr !== 32'h0) begin errors++; $display("FAIL clear_cnt: got %0d/%0d/%h want 0/0/00000000", word_count, err_count, out_addr); end
    endtask

    initial begin
        test_reset();
        test_itype();
        test_back_to_back();
        test_stall();
        test_encodings();
        test_errors();
        test_err_saturation();
        test_wrap();
        test_async_reset();
        test_clear_with_accept();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
